// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read-side consumer for the team FIFO. Pops a word whenever the FIFO is
//   non-empty and the transmitter is idle. Each word goes out on an asynchronous
//   serial line as: start bit (0), B data bits LSB first, optional even parity
//   bit, STOP_BITS stop bits (1). The line idles high.
//
// Parameters
//   B             data bits per word, must match the FIFO word width
//   CLKS_PER_BIT  clk cycles per serial bit, >= 2
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   fifo_empty    in   FIFO empty flag; fifo_r_data is valid while low
//   fifo_r_data   in   FIFO head word (first-word-fall-through)
//   fifo_rd       out  one-cycle pop strobe, FIFO samples it on the same edge
//   tx            out  registered serial line, idles high
//   tx_busy       out  high while a frame is in progress
//   tx_done_tick  out  one-cycle pulse in the last cycle of the stop period
//
// Configuration
//   FIFO_UART_TX_PARITY_EN  when defined, an even-parity bit follows the data
//                           bits. When undefined, DATA goes straight to STOP.

module fifo_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done_tick
);

  // Elaboration-time parameter checks
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  // The tick counter must reach the longest period, which is the stop period.
  localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(B + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(B - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state, state_next;
  logic [TW-1:0] tick_cnt, tick_next;
  logic [BW-1:0] bit_cnt, bit_next;
  logic [B-1:0]  shreg, shreg_next;
  logic          tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_q, parity_next;
`endif

  // Next-state logic. Both counters return to zero on every state change so
  // each state counts its own period from zero. The pop strobe is held off
  // while reset is asserted so nothing is consumed during reset.
  always_comb begin
    state_next   = state;
    tick_next    = tick_cnt + 1'b1;
    bit_next     = bit_cnt;
    shreg_next   = shreg;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_next  = parity_q;
`endif

    case (state)
      IDLE: begin
        tick_next = '0;
        bit_next  = '0;
        if (reset && !fifo_empty) begin
          fifo_rd    = 1'b1;
          shreg_next = fifo_r_data;
          state_next = START;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_next = ^fifo_r_data;
`endif
        end
      end

      START: begin
        if (tick_cnt == BIT_LAST) begin
          tick_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end

      DATA: begin
        if (tick_cnt == BIT_LAST) begin
          tick_next  = '0;
          shreg_next = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick_cnt == BIT_LAST) begin
          tick_next  = '0;
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (tick_cnt == STOP_LAST) begin
          tx_done_tick = 1'b1;
          tick_next    = '0;
          state_next   = IDLE;
        end
      end

      default: begin
        tick_next  = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // The line level is derived from where the FSM is going next, so the
  // registered tx lines up exactly with the state it belongs to.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // State, counters, shift register and the registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity is captured at pop time because the shift register is consumed
  // by the time the parity bit goes out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_next;
    end
  end
`endif

  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx with B=8, CLKS_PER_BIT=16, STOP_BITS=1. A small
//   first-word-fall-through FIFO model feeds the design; expected frames are
//   hand-written constants in a vector table (bit 0 = first bit on the line).
//   Define FIFO_UART_TX_PARITY_EN for both files to exercise the parity build.

module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  logic [7:0] fifo_q[$];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  word;
    logic [10:0] frame;
    bit          queued;
    bit          tight;
  } vec_t;

  vec_t vecs[6];

  fifo_uart_tx #(.B(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // Advance one clock; the FIFO model pops on the edge where fifo_rd was high.
  task automatic apply_stimulus();
    logic rd_seen;
    rd_seen = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    update_fifo();
    @(negedge clk);
  endtask

  // Wait (bounded) for a pop, or demand it right now when tight is set.
  task automatic wait_pop(input string name, input bit tight, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd) begin
        ok = 1'b1;
        break;
      end
      if (tight) break;
      apply_stimulus();
    end
    check_output({name, " pop"}, int'(ok), 1);
  endtask

  // Entered in the pop cycle (cycle 0); returns in the gap cycle after the frame.
  task automatic check_frame(input string name, input logic [10:0] frame);
    int extra_rd = 0, busy_low = 0, done_cnt = 0, done_at = -1;
    check_output({name, " idle tx at pop"}, int'(tx), 1);
    check_output({name, " busy at pop"}, int'(tx_busy), 0);
    for (int b = 0; b < NB; b++) begin
      logic seen;
      bit   err = 1'b0;
      seen = frame[b];
      for (int k = 0; k < CPB; k++) begin
        apply_stimulus();
        if (tx !== frame[b] && !err) begin
          err  = 1'b1;
          seen = tx;
        end
        if (fifo_rd) extra_rd++;
        if (!tx_busy) busy_low++;
        if (tx_done_tick) begin
          done_cnt++;
          done_at = b * CPB + k + 1;
        end
      end
      check_output($sformatf("%s bit%0d", name, b), int'(seen), int'(frame[b]));
    end
    check_output({name, " extra pops"}, extra_rd, 0);
    check_output({name, " busy drops"}, busy_low, 0);
    check_output({name, " done count"}, done_cnt, 1);
    check_output({name, " done cycle"}, done_at, NB * CPB);
    apply_stimulus();
    check_output({name, " busy after"}, int'(tx_busy), 0);
    check_output({name, " gap tx"}, int'(tx), 1);
  endtask

  initial begin
    bit ok;
    int rd_cnt, tx_low, busy_cnt;

`ifdef FIFO_UART_TX_PARITY_EN
    vecs[0] = '{8'h0A, 11'b10000010100, 1'b1, 1'b0};
    vecs[1] = '{8'h0A, 11'b10000010100, 1'b0, 1'b0};
    vecs[2] = '{8'h14, 11'b10000101000, 1'b1, 1'b1};
    vecs[3] = '{8'h1E, 11'b10000111100, 1'b1, 1'b1};
    vecs[4] = '{8'h28, 11'b10001010000, 1'b1, 1'b1};
    vecs[5] = '{8'h07, 11'b11000001110, 1'b0, 1'b0};
`else
    vecs[0] = '{8'h0A, 11'b1000010100, 1'b1, 1'b0};
    vecs[1] = '{8'h0A, 11'b1000010100, 1'b0, 1'b0};
    vecs[2] = '{8'h14, 11'b1000101000, 1'b1, 1'b1};
    vecs[3] = '{8'h1E, 11'b1000111100, 1'b1, 1'b1};
    vecs[4] = '{8'h28, 11'b1001010000, 1'b1, 1'b1};
    vecs[5] = '{8'h07, 11'b1000001110, 1'b0, 1'b0};
`endif

    // Reset held with a word waiting: nothing may move.
    reset = 1'b0;
    fifo_q.push_back(vecs[0].word);
    update_fifo();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("reset%0d tx", i), int'(tx), 1);
      check_output($sformatf("reset%0d rd", i), int'(fifo_rd), 0);
      check_output($sformatf("reset%0d busy", i), int'(tx_busy), 0);
      check_output($sformatf("reset%0d done", i), int'(tx_done_tick), 0);
    end
    reset = 1'b1;
    #1;

    // Table: single word, back-to-back burst, and a trailing word.
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].queued) begin
        fifo_q.push_back(vecs[i].word);
        for (int j = i + 1; j < 6 && vecs[j].queued; j++) fifo_q.push_back(vecs[j].word);
        update_fifo();
        #1;
      end
      wait_pop($sformatf("v%0d", i), vecs[i].tight, ok);
      if (ok) check_frame($sformatf("v%0d w%02h", i, vecs[i].word), vecs[i].frame);
    end

    // Empty FIFO for 500 cycles.
    rd_cnt = 0; tx_low = 0; busy_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      apply_stimulus();
      if (fifo_rd) rd_cnt++;
      if (!tx) tx_low++;
      if (tx_busy) busy_cnt++;
    end
    check_output("empty pops", rd_cnt, 0);
    check_output("empty tx low", tx_low, 0);
    check_output("empty busy", busy_cnt, 0);

    // Reset in the middle of data bit 3 of 0xFF, then 0x55 framed cleanly.
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h55);
    update_fifo();
    #1;
    wait_pop("ff", 1'b0, ok);
    if (ok) begin
      for (int c = 1; c <= 70; c++) apply_stimulus();
      check_output("ff bit3 tx", int'(tx), 1);
      check_output("ff bit3 busy", int'(tx_busy), 1);
      reset = 1'b0;
      #1;
      check_output("midreset busy", int'(tx_busy), 0);
      check_output("midreset rd", int'(fifo_rd), 0);
      apply_stimulus();
      apply_stimulus();
      check_output("midreset tx", int'(tx), 1);
      check_output("midreset held rd", int'(fifo_rd), 0);
      reset = 1'b1;
      #1;
      wait_pop("55", 1'b0, ok);
`ifdef FIFO_UART_TX_PARITY_EN
      if (ok) check_frame("w55", 11'b10010101010);
`else
      if (ok) check_frame("w55", 11'b1010101010);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
